msx_bus_initiator: RTL and testbench
====================================

// Module: msx_bus_initiator
// PURPOSE
//  Host-side MSX slot bus cycle generator: other end of the cartridge bus the slot-expanded carts respond on.
//  Turns one request (valid/ready) into one Z80-timed memory or I/O read/write cycle, honours WAIT_n, returns read data.
//  Used as an on-chip master driving the cartridge bus (bring-up, self-test, bench stimulus for cart blocks).
// PARAMETERS
//  IO_AUTO_WAIT   1     insert one mandatory TW state on I/O cycles (Z80 behaviour); 0 = none
//  WAIT_TIMEOUT   1024  max TW states per cycle before abort; 1..65535
//  TW_W           16    width of TW counter; >= clog2(WAIT_TIMEOUT+1)
// PORTS
//  CLK        in   1   system clock; the only clock
//  RESET      in   1   synchronous reset, active high
//  CLK_EN     in   1   T-state strobe (1 CLK wide, ~3.58 MHz rate); FSM advances only when high
//  REQ_VALID  in   1   request present
//  REQ_READY  out  1   request accepted when VALID&READY
//  REQ_WRITE  in   1   1 = write, 0 = read
//  REQ_IO     in   1   1 = I/O cycle (IORQ_n), 0 = memory (MREQ_n + SLTSL_n)
//  REQ_ADDR   in   16  bus address
//  REQ_DATA   in   8   write data
//  RSP_VALID  out  1   one-CLK pulse: cycle finished
//  RSP_DATA   out  8   read data (write: 8'h00; timeout: 8'hFF); held until next RSP_VALID
//  RSP_ERR    out  1   WAIT timeout on that cycle; qualified by RSP_VALID
//  ADDR       out  16  bus address
//  DOUT       out  8   bus write data
//  DIN        in   8   bus read data
//  SLTSL_n / MREQ_n / IORQ_n / RD_n / WR_n  out 1 each  bus strobes, active low
//  WAIT_n     in   1   bus wait, active low
// BEHAVIOUR
//  Reset: state IDLE; REQ_READY=1, RSP_VALID=0, RSP_ERR=0, RSP_DATA=8'h00, ADDR=0, DOUT=0, all strobes 1.
//  States IDLE, T1, T2, TW, T3; each non-IDLE state lasts exactly one CLK_EN period.
//  IDLE: READY=1. Handshake on any CLK (CLK_EN not required): latch WRITE/IO/ADDR/DATA, READY->0, go T1.
//  T1: ADDR=latched addr, DOUT=latched data (writes; 0 on reads); all strobes high. Next CLK_EN -> T2.
//  T2: assert MREQ_n (mem) or IORQ_n (io), SLTSL_n (mem only), RD_n (read) or WR_n (write).
//   At CLK_EN: TW if (IO & IO_AUTO_WAIT & first TW not yet done) or WAIT_n==0; else T3.
//  TW: strobes held; TW counter +1 per CLK_EN. At CLK_EN: WAIT_n==1 (and auto-wait done) -> T3;
//   counter reaches WAIT_TIMEOUT -> T3 with abort flag set.
//  T3: strobes held. At CLK_EN: read samples DIN into RSP_DATA (abort: 8'hFF); RSP_VALID=1 for 1 CLK;
//   RSP_ERR=abort; strobes all 1 same edge; READY=1 same edge; -> IDLE. ADDR/DOUT hold until next T1.
//  Latency: request to RSP_VALID = 3 + nTW CLK_EN periods (plus <1 period alignment to first CLK_EN).
//  Strobes never glitch: registered outputs, change only on state transitions.
//  WAIT_n sampled only on CLK_EN edges in T2/TW; WAIT_n during T1/T3/IDLE ignored.
//  Back-to-back: new request may be accepted the CLK after RSP_VALID; T1 of it is >=1 CLK_EN later
//   so strobes are high for >=1 full T-state between cycles.
//  REQ_* changes while READY=0 ignored (latched copy used). RESET mid-cycle: next edge IDLE,
//   strobes high, no RSP_VALID for aborted cycle. RESET overrides CLK_EN and REQ_VALID.
//  Timeout count saturates; WAIT_TIMEOUT reached exactly on Nth TW -> abort (N = WAIT_TIMEOUT).
// STRUCTURE
//  Package msx_bus_pkg: typedef enum {IDLE,T1,T2,TW,T3} bus_state_t; typedef struct req_t
//   {write, io, addr[15:0], data[7:0]}; localparam RSP_DATA_TIMEOUT = 8'hFF.
//  Sub-module bus_wait_timer (clear, inc on CLK_EN, 'expired' at WAIT_TIMEOUT); rest is one FSM.
// TESTING
//  Mem read A=16'h4000, DIN=8'h5A, WAIT_n=1 -> SLTSL_n/MREQ_n/RD_n low for 2 CLK_EN periods, RSP_DATA=5A, ERR=0.
//  I/O write A=16'h0098 D=8'hC3, IO_AUTO_WAIT=1 -> IORQ_n/WR_n low 3 periods, SLTSL_n stays 1, DOUT=C3.
//  Mem read with WAIT_n low for 5 CLK_EN in T2 -> exactly 5 TW, RSP_VALID at period 8, data sampled after release.
//  WAIT_n stuck low, WAIT_TIMEOUT=4 -> 4 TW, RSP_VALID with ERR=1, RSP_DATA=FF, strobes released.
//  Two queued requests (VALID held) -> strobes high >=1 CLK_EN period between cycles; both RSP correct.
//  RESET asserted in TW -> next CLK all strobes 1, READY=1, no RSP_VALID; following request works normally.

Source files
------------

// File: rtl/msx_bus_pkg.sv
// Shared types for the MSX slot bus initiator.
// Bus cycle states, latched request bundle and timeout data value.
package msx_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        TW,
        T3
    } bus_state_t;

    typedef struct packed {
        logic        write;
        logic        io;
        logic [15:0] addr;
        logic [7:0]  data;
    } req_t;

    localparam logic [7:0] RSP_DATA_TIMEOUT = 8'hFF;

endpackage

// File: rtl/bus_wait_timer.sv
// Counts TW states of one bus cycle and flags the one that hits the limit.
// Cleared outside TW; the count saturates at WAIT_TIMEOUT.
module bus_wait_timer #(
    parameter int WAIT_TIMEOUT = 1024,
    parameter int TW_W         = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [TW_W-1:0] LIMIT = TW_W'(WAIT_TIMEOUT);

    logic [TW_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    // high on the CLK_EN edge that closes the Nth TW state
    assign expired = inc && (count >= LIMIT - 1'b1);

endmodule

// File: rtl/msx_bus_initiator.sv
// Host-side MSX slot bus cycle generator: one request becomes one
// Z80-timed memory or I/O cycle (T1,T2,TW*,T3) with WAIT_n support.
module msx_bus_initiator
    import msx_bus_pkg::*;
#(
    parameter bit IO_AUTO_WAIT = 1'b1,
    parameter int WAIT_TIMEOUT = 1024,
    parameter int TW_W         = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CLK_EN,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic        REQ_IO,
    input  logic [15:0] REQ_ADDR,
    input  logic [7:0]  REQ_DATA,
    output logic        RSP_VALID,
    output logic [7:0]  RSP_DATA,
    output logic        RSP_ERR,
    output logic [15:0] ADDR,
    output logic [7:0]  DOUT,
    input  logic [7:0]  DIN,
    output logic        SLTSL_n,
    output logic        MREQ_n,
    output logic        IORQ_n,
    output logic        RD_n,
    output logic        WR_n,
    input  logic        WAIT_n
);

    bus_state_t state;
    req_t       req;
    logic       aligned;
    logic       abort;
    logic       tmr_clear;
    logic       tmr_inc;
    logic       expired;

    assign tmr_clear = (state != TW);
    assign tmr_inc   = (state == TW) && CLK_EN;

    bus_wait_timer #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT),
        .TW_W        (TW_W)
    ) u_timer (
        .clk    (CLK),
        .reset  (RESET),
        .clear  (tmr_clear),
        .inc    (tmr_inc),
        .expired(expired)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            req       <= '0;
            aligned   <= 1'b0;
            abort     <= 1'b0;
            REQ_READY <= 1'b1;
            RSP_VALID <= 1'b0;
            RSP_ERR   <= 1'b0;
            RSP_DATA  <= 8'h00;
            ADDR      <= 16'h0000;
            DOUT      <= 8'h00;
            SLTSL_n   <= 1'b1;
            MREQ_n    <= 1'b1;
            IORQ_n    <= 1'b1;
            RD_n      <= 1'b1;
            WR_n      <= 1'b1;
        end else begin
            RSP_VALID <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        req.write <= REQ_WRITE;
                        req.io    <= REQ_IO;
                        req.addr  <= REQ_ADDR;
                        req.data  <= REQ_DATA;
                        aligned   <= CLK_EN;
                        abort     <= 1'b0;
                        REQ_READY <= 1'b0;
                        state     <= T1;
                    end
                end
                T1: begin
                    ADDR <= req.addr;
                    DOUT <= req.write ? req.data : 8'h00;
                    // T1 proper starts on the first CLK_EN after accept
                    if (CLK_EN) begin
                        if (aligned) begin
                            SLTSL_n <= req.io;
                            MREQ_n  <= req.io;
                            IORQ_n  <= !req.io;
                            RD_n    <= req.write;
                            WR_n    <= !req.write;
                            state   <= T2;
                        end else begin
                            aligned <= 1'b1;
                        end
                    end
                end
                T2: begin
                    if (CLK_EN) begin
                        if ((req.io && IO_AUTO_WAIT) || !WAIT_n) begin
                            state <= TW;
                        end else begin
                            state <= T3;
                        end
                    end
                end
                TW: begin
                    if (CLK_EN) begin
                        if (WAIT_n) begin
                            state <= T3;
                        end else if (expired) begin
                            abort <= 1'b1;
                            state <= T3;
                        end
                    end
                end
                T3: begin
                    if (CLK_EN) begin
                        RSP_VALID <= 1'b1;
                        RSP_ERR   <= abort;
                        if (abort) begin
                            RSP_DATA <= RSP_DATA_TIMEOUT;
                        end else begin
                            RSP_DATA <= req.write ? 8'h00 : DIN;
                        end
                        SLTSL_n   <= 1'b1;
                        MREQ_n    <= 1'b1;
                        IORQ_n    <= 1'b1;
                        RD_n      <= 1'b1;
                        WR_n      <= 1'b1;
                        REQ_READY <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msx_bus_initiator.sv
// Scoreboard bench for msx_bus_initiator: two instances (default and
// WAIT_TIMEOUT=4), directed bus cycles, monitor checks every response.
module tb_msx_bus_initiator;

    typedef struct {
        int          dut;
        logic        write;
        logic        io;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        err;
        int          ntw;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en = 1'b0;
    logic [1:0]  en_cnt = 2'd0;
    logic        req_valid [2];
    logic        req_write;
    logic        req_io;
    logic [15:0] req_addr;
    logic [7:0]  req_data;
    logic [7:0]  din;
    logic        wait_n;

    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_err   [2];
    logic [7:0]  rsp_data  [2];
    logic [15:0] addr      [2];
    logic [7:0]  dout      [2];
    logic        sltsl_n   [2];
    logic        mreq_n    [2];
    logic        iorq_n    [2];
    logic        rd_n      [2];
    logic        wr_n      [2];

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        en_cnt <= en_cnt + 2'd1;
        clk_en <= (en_cnt == 2'd2);
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        msx_bus_initiator #(
            .IO_AUTO_WAIT(1'b1),
            .WAIT_TIMEOUT(g == 0 ? 1024 : 4),
            .TW_W        (16)
        ) dut (
            .CLK      (clk),
            .RESET    (reset),
            .CLK_EN   (clk_en),
            .REQ_VALID(req_valid[g]),
            .REQ_READY(req_ready[g]),
            .REQ_WRITE(req_write),
            .REQ_IO   (req_io),
            .REQ_ADDR (req_addr),
            .REQ_DATA (req_data),
            .RSP_VALID(rsp_valid[g]),
            .RSP_DATA (rsp_data[g]),
            .RSP_ERR  (rsp_err[g]),
            .ADDR     (addr[g]),
            .DOUT     (dout[g]),
            .DIN      (din),
            .SLTSL_n  (sltsl_n[g]),
            .MREQ_n   (mreq_n[g]),
            .IORQ_n   (iorq_n[g]),
            .RD_n     (rd_n[g]),
            .WR_n     (wr_n[g]),
            .WAIT_n   (wait_n)
        );
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: per-DUT cycle measurements, compared at each RSP_VALID
    int lat  [2];
    int lowp [2];
    int gap  [2];
    bit had  [2];
    bit prev_low [2];
    bit s_sl [2];
    bit s_mr [2];
    bit s_io [2];
    bit s_rd [2];
    bit s_wr [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            lat[d] = 0; lowp[d] = 0; gap[d] = 0; had[d] = 0;
            prev_low[d] = 0; s_sl[d] = 0; s_mr[d] = 0;
            s_io[d] = 0; s_rd[d] = 0; s_wr[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                bit   any_low;
                exp_t e;
                any_low = !sltsl_n[d] || !mreq_n[d] || !iorq_n[d]
                          || !rd_n[d] || !wr_n[d];
                if (reset) begin
                    lat[d] = 0; lowp[d] = 0; gap[d] = 0; had[d] = 0;
                    s_sl[d] = 0; s_mr[d] = 0; s_io[d] = 0;
                    s_rd[d] = 0; s_wr[d] = 0;
                end else if (rsp_valid[d]) begin
                    if (sb.size() == 0 || sb[0].dut != d) begin
                        checks++;
                        errors++;
                        $display("FAIL d%0d rsp_unexpected: got RSP_VALID, expected none", d);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("d%0d rsp_data", d), 32'(rsp_data[d]), 32'(e.rdata));
                        chk($sformatf("d%0d rsp_err", d), 32'(rsp_err[d]), 32'(e.err));
                        chk($sformatf("d%0d addr", d), 32'(addr[d]), 32'(e.addr));
                        chk($sformatf("d%0d dout", d), 32'(dout[d]),
                            32'(e.write ? e.wdata : 8'h00));
                        chk($sformatf("d%0d latency", d), 32'(lat[d]), 32'(e.ntw + 4));
                        chk($sformatf("d%0d low_periods", d), 32'(lowp[d]), 32'(e.ntw + 2));
                        chk($sformatf("d%0d sltsl_low", d), 32'(s_sl[d]), 32'(!e.io));
                        chk($sformatf("d%0d mreq_low", d), 32'(s_mr[d]), 32'(!e.io));
                        chk($sformatf("d%0d iorq_low", d), 32'(s_io[d]), 32'(e.io));
                        chk($sformatf("d%0d rd_low", d), 32'(s_rd[d]), 32'(!e.write));
                        chk($sformatf("d%0d wr_low", d), 32'(s_wr[d]), 32'(e.write));
                        chk($sformatf("d%0d released", d),
                            32'({sltsl_n[d], mreq_n[d], iorq_n[d], rd_n[d], wr_n[d]}),
                            32'h1F);
                        chk($sformatf("d%0d ready", d), 32'(req_ready[d]), 32'h1);
                    end
                    lat[d] = 0; lowp[d] = 0; gap[d] = 0; had[d] = 1;
                    s_sl[d] = 0; s_mr[d] = 0; s_io[d] = 0;
                    s_rd[d] = 0; s_wr[d] = 0;
                end else begin
                    if (!req_ready[d] && clk_en) lat[d]++;
                    if (clk_en && (!mreq_n[d] || !iorq_n[d])) lowp[d]++;
                    if (!sltsl_n[d]) s_sl[d] = 1;
                    if (!mreq_n[d]) s_mr[d] = 1;
                    if (!iorq_n[d]) s_io[d] = 1;
                    if (!rd_n[d]) s_rd[d] = 1;
                    if (!wr_n[d]) s_wr[d] = 1;
                    if (any_low && !prev_low[d] && had[d]) begin
                        chk($sformatf("d%0d idle_gap", d), 32'(gap[d] >= 1), 32'h1);
                    end
                    if (any_low) gap[d] = 0;
                    else if (clk_en) gap[d]++;
                end
                prev_low[d] = any_low;
            end
        end
    end

    task automatic en_edge();
        do @(negedge clk); while (!clk_en);
        @(posedge clk);
    endtask

    task automatic issue(input int d, input bit wr, input bit io,
                         input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] rexp, input bit err,
                         input int ntw, input int nwait);
        exp_t e;
        int   k;
        do @(negedge clk); while (!clk_en);
        @(posedge clk);
        #2;
        req_valid[d] = 1'b1;
        req_write    = wr;
        req_io       = io;
        req_addr     = a;
        req_data     = wd;
        e.dut = d; e.write = wr; e.io = io; e.addr = a;
        e.wdata = wd; e.rdata = rexp; e.err = err; e.ntw = ntw;
        sb.push_back(e);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!req_ready[d] && k < 400);
        chk($sformatf("d%0d accept", d), 32'(req_ready[d]), 32'h1);
        @(posedge clk);
        #2;
        req_valid[d] = 1'b0;
        req_write    = !wr;
        req_io       = !io;
        req_addr     = ~a;
        req_data     = ~wd;
        if (nwait > 0) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (mreq_n[d] && iorq_n[d] && k < 100);
            wait_n = 1'b0;
            repeat (nwait) en_edge();
            #2;
            wait_n = 1'b1;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 32'(sb.size()), 32'h0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int k;
        reset        = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        req_write    = 1'b0;
        req_io       = 1'b0;
        req_addr     = 16'h0000;
        req_data     = 8'h00;
        din          = 8'h00;
        wait_n       = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d rst_ready", d), 32'(req_ready[d]), 32'h1);
            chk($sformatf("d%0d rst_rsp_valid", d), 32'(rsp_valid[d]), 32'h0);
            chk($sformatf("d%0d rst_rsp_err", d), 32'(rsp_err[d]), 32'h0);
            chk($sformatf("d%0d rst_rsp_data", d), 32'(rsp_data[d]), 32'h0);
            chk($sformatf("d%0d rst_addr", d), 32'(addr[d]), 32'h0);
            chk($sformatf("d%0d rst_dout", d), 32'(dout[d]), 32'h0);
            chk($sformatf("d%0d rst_strobes", d),
                32'({sltsl_n[d], mreq_n[d], iorq_n[d], rd_n[d], wr_n[d]}), 32'h1F);
        end

        din = 8'h5A;
        issue(0, 1'b0, 1'b0, 16'h4000, 8'h00, 8'h5A, 1'b0, 0, 0);
        drain();

        issue(0, 1'b1, 1'b1, 16'h0098, 8'hC3, 8'h00, 1'b0, 1, 0);
        drain();

        din = 8'h3C;
        issue(0, 1'b0, 1'b0, 16'h8000, 8'h00, 8'h3C, 1'b0, 5, 5);
        drain();

        din = 8'h77;
        issue(0, 1'b1, 1'b0, 16'h4123, 8'hA5, 8'h00, 1'b0, 0, 0);
        issue(0, 1'b0, 1'b1, 16'h0099, 8'h00, 8'h77, 1'b0, 1, 0);
        drain();

        wait_n = 1'b0;
        din    = 8'h5A;
        issue(0, 1'b0, 1'b0, 16'hBEEF, 8'h00, 8'h5A, 1'b0, 0, 0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (mreq_n[0] && k < 100);
        en_edge();
        en_edge();
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk("d0 tw_rst_strobes",
            32'({sltsl_n[0], mreq_n[0], iorq_n[0], rd_n[0], wr_n[0]}), 32'h1F);
        chk("d0 tw_rst_ready", 32'(req_ready[0]), 32'h1);
        chk("d0 tw_rst_rsp_valid", 32'(rsp_valid[0]), 32'h0);
        reset  = 1'b0;
        wait_n = 1'b1;
        void'(sb.pop_back());
        repeat (12) @(negedge clk);

        din = 8'hE1;
        issue(0, 1'b0, 1'b0, 16'hC000, 8'h00, 8'hE1, 1'b0, 0, 0);
        drain();

        issue(0, 1'b1, 1'b0, 16'h2001, 8'h5C, 8'h00, 1'b0, 2, 2);
        drain();

        wait_n = 1'b0;
        issue(1, 1'b0, 1'b0, 16'h1234, 8'h00, 8'hFF, 1'b1, 4, 0);
        drain();
        wait_n = 1'b1;

        wait_n = 1'b0;
        issue(1, 1'b1, 1'b1, 16'h00A8, 8'h42, 8'hFF, 1'b1, 4, 0);
        drain();
        wait_n = 1'b1;

        din = 8'h99;
        issue(1, 1'b0, 1'b0, 16'h0001, 8'h00, 8'h99, 1'b0, 0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

endmodule
